// File: rtl/cnn_pkg.sv
// Shared encodings for the row-vector stream buffer mux: operating modes and
// controller state values.
package cnn_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_STATIC_ENC = 2'd1;
  localparam logic [1:0] ST_SEQ_ENC    = 2'd2;
  localparam logic [1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_STATIC = ST_STATIC_ENC,
    ST_SEQ    = ST_SEQ_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/chan_mask_next.sv
// Finds the lowest set mask bit strictly above cur. Driving cur with -1
// (all ones, signed) returns the first enabled channel.
module chan_mask_next #(
  parameter int num_inputs = 5,
  parameter int sel_width  = $clog2(num_inputs)
) (
  input  logic [num_inputs-1:0]   mask,
  input  logic signed [sel_width:0] cur,
  output logic [sel_width-1:0]    next_chan,
  output logic                    has_next
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_chan = '0;
    has_next  = 1'b0;
    // Scanning downward lets the lowest qualifying bit win.
    for (int k = num_inputs - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur))) begin
        next_chan = sel_width'(k);
        has_next  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_buffer_mux.sv
// Registered N-way row-vector selector feeding the systolic array row-load
// port; static single-channel forwarding or masked burst sequencing.
module stream_buffer_mux
  import cnn_pkg::*;
#(
  parameter int array_size  = 9,
  parameter int data_size   = 16,
  parameter int num_inputs  = 5,
  parameter int sel_width   = $clog2(num_inputs),
  parameter int burst_width = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [num_inputs*array_size*data_size-1:0] in_data,
  input  logic [num_inputs-1:0]                  in_valid,
  output logic [num_inputs-1:0]                  in_ready,
  input  logic                                   mode,
  input  logic [sel_width-1:0]                   static_sel,
  input  logic [num_inputs-1:0]                  chan_mask,
  input  logic [burst_width-1:0]                 burst_len,
  input  logic                                   start,
  input  logic                                   stop,
  output logic [array_size*data_size-1:0]        out_data,
  output logic [sel_width-1:0]                   out_chan,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int row_w = array_size * data_size;

  state_t                 state_q,     state_d;
  logic [sel_width-1:0]   cur_q,       cur_d;
  logic [burst_width-1:0] beat_q,      beat_d;
  logic [burst_width-1:0] burst_q,     burst_d;
  logic [num_inputs-1:0]  mask_q,      mask_d;
  logic [row_w-1:0]       out_data_q,  out_data_d;
  logic [sel_width-1:0]   out_chan_q,  out_chan_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q,       err_d;

  logic                 active, cap, beat_fire, last_beat;
  logic [sel_width-1:0] first_chan, next_chan;
  logic                 first_ok, has_next;

  chan_mask_next #(.num_inputs(num_inputs), .sel_width(sel_width)) u_first (
    .mask      (chan_mask),
    .cur       ({(sel_width + 1){1'b1}}),
    .next_chan (first_chan),
    .has_next  (first_ok)
  );

  chan_mask_next #(.num_inputs(num_inputs), .sel_width(sel_width)) u_next (
    .mask      (mask_q),
    .cur       ({1'b0, cur_q}),
    .next_chan (next_chan),
    .has_next  (has_next)
  );

  // The output slot can take a beat when empty or being drained this cycle.
  always_comb begin
    active    = (state_q == ST_STATIC) || (state_q == ST_SEQ);
    cap       = !out_valid_q || out_ready;
    beat_fire = active && cap && in_valid[cur_q];
    last_beat = (beat_q == burst_q - burst_width'(1));
    in_ready  = '0;
    if (active && cap) in_ready[cur_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    mask_d      = mask_q;
    err_d       = 1'b0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;

    if (beat_fire) begin
      out_data_d  = in_data[int'(cur_q)*row_w +: row_w];
      out_chan_d  = cur_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_STATIC) begin
            if (int'(static_sel) < num_inputs) begin
              cur_d   = static_sel;
              state_d = ST_STATIC;
            end else begin
              err_d = 1'b1;
            end
          end else if (first_ok && (burst_len != '0)) begin
            cur_d   = first_chan;
            beat_d  = '0;
            mask_d  = chan_mask;
            burst_d = burst_len;
            state_d = ST_SEQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_STATIC: begin
        if (stop) state_d = ST_IDLE;
      end
      ST_SEQ: begin
        // Channel hand-off happens on the last beat itself, so no bubble.
        if (beat_fire) begin
          if (last_beat) begin
            beat_d = '0;
            if (has_next) cur_d   = next_chan;
            else          state_d = ST_DONE;
          end else begin
            beat_d = beat_q + burst_width'(1);
          end
        end
        if (stop) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      beat_q      <= '0;
      burst_q     <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: doc/stream_buffer_mux.md
Name: stream_buffer_mux

Overview:
- Parametrised, registered successor to the combinational 5-way buffer select that feeds row vectors into the systolic array.
- Selects one of num_inputs row-vector channels and forwards it through a one-deep output register with valid/ready handshakes.
- Two modes:
  - static: forward one channel until stopped.
  - sequence: walk the channels enabled in a mask, moving burst_len beats from each, then signal done.
- Sits between the on-chip input/weight buffers and the array's row-load port.

Parameters:
- array_size, 9, elements per row vector
- data_size, 16, bits per element
- num_inputs, 5, number of source channels (≥2)
- sel_width, $clog2(num_inputs), channel index width
- burst_width, 8, width of burst_len and beat counter

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_data  in  num_inputs*array_size*data_size  channel k occupies bits [(k+1)*array_size*data_size-1 : k*array_size*data_size]
- in_valid  in  num_inputs  per-channel valid
- in_ready  out  num_inputs  per-channel ready; at most one bit high
- mode  in  1  0=static, 1=sequence; sampled on start
- static_sel  in  sel_width  channel for static mode; sampled on start
- chan_mask  in  num_inputs  channels enabled in sequence mode; sampled on start
- burst_len  in  burst_width  beats per channel in sequence mode; sampled on start
- start  in  1  begin operation; honoured only in IDLE
- stop  in  1  abort/end operation; ignored in IDLE
- out_data  out  array_size*data_size  registered row vector
- out_chan  out  sel_width  source channel of out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- busy  out  1  state≠IDLE or out_valid
- done  out  1  one-cycle pulse at end of sequence
- err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - out_data=0, out_chan=0, out_valid=0, done=0, err=0, in_ready=0.
  - Beat and channel counters=0.
  - Applies mid-operation: an in-flight beat is dropped with no done or err.
- States: IDLE, STATIC, SEQ, DONE.
- Transfer enable: cap = !out_valid || out_ready.
- in_ready[cur] = cap when state ∈ {STATIC, SEQ}; all other in_ready bits = 0.
- Input beat: in_valid[cur] && in_ready[cur].
  - Next edge: out_data=channel cur, out_chan=cur, out_valid=1.
  - Latency is 1 cycle.
  - With out_ready held high, throughput is 1 beat per cycle.
- Output handshake: out_valid && out_ready with no new beat → out_valid=0.
  - out_data and out_valid hold while out_valid && !out_ready.
- IDLE + start:
  - mode=0, static_sel < num_inputs → cur=static_sel, go STATIC.
  - mode=0, static_sel ≥ num_inputs → err pulse, stay IDLE.
  - mode=1, chan_mask≠0 and burst_len≠0 → cur=lowest set mask bit, beat=0, go SEQ.
  - mode=1, chan_mask=0 or burst_len=0 → err pulse, stay IDLE.
- STATIC: forward cur indefinitely; stop → IDLE next edge. A beat in the same cycle as stop is still accepted.
- SEQ: beat increments on each input beat. When the beat count reaches burst_len-1 on an input beat:
  - If a higher mask bit is set: cur=next set bit above cur, beat=0, with no bubble cycle.
  - Otherwise: go DONE.
- SEQ + stop: go IDLE next edge, no done pulse. A beat accepted in that same cycle completes normally.
- DONE: done=1 for exactly one cycle, then IDLE. in_ready=0 throughout.
- start while not IDLE: ignored, no err.
- The last beat stays in the output register after IDLE until consumed; busy stays 1 until then.
- Widths:
  - Beat compare uses burst_width bits; burst_len=2^burst_width-1 is legal.
  - No arithmetic on data; out_data is a bit-exact copy.

Decomposition:
- Shared package (cnn_pkg): mode encodings MODE_STATIC=0 and MODE_SEQ=1; state encoding localparams for IDLE, STATIC, SEQ, DONE.
- Sub-module chan_mask_next, purely combinational:
  - Inputs: mask, cur.
  - Outputs: the lowest set bit strictly above cur, and a has_next flag.
  - The same block, with cur forced below 0, yields the first channel.

Test Plan:
- Static: reset; start, mode=0, static_sel=2; in_valid[2]=1 with data 0xA..; out_ready=1 → out_chan=2 and out_data matches one cycle later; in_ready=5'b00100; stop → IDLE, busy drops once the output drains.
- Sequence: chan_mask=5'b10110, burst_len=3, all in_valid=1, out_ready=1 → out_chan sequence 1,1,1,2,2,2,4,4,4 on consecutive cycles; done pulses once the cycle after the 9th input beat.
- Backpressure: sequence as above, out_ready toggled 1,0,0,1 → no beat lost or duplicated; out_data stable while stalled; total of 9 outputs in order.
- Errors: start with mode=0, static_sel=7; then mode=1, chan_mask=0; then mode=1, burst_len=0 → err pulses each time, state stays IDLE, in_ready=0.
- Interrupt: mid-sequence (after 4 beats), stop asserted → IDLE next edge, no done. Repeat with reset_n=0 at beat 4 → all outputs zero next edge, out_valid=0.
- start asserted during SEQ → ignored; sequence completes unchanged with a single done pulse.
